axis_tx_frame_gen: RTL

//  AXI-Stream frame source for the 10G MAC transmit path; drives the MAC tx_axis_* slave port

---
 rtl/axis_tx_frame_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axis_tx_frame_gen.sv
// AXI-Stream frame source for the 10G MAC transmit path: bursts of fixed-length frames with
// deterministic byte-ramp payload, optional inter-frame gap, error marking and graceful abort.
module axis_tx_frame_gen #(
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 16,
  parameter int IFG_CYCLES = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [LEN_W-1:0]    num_frames,
  input  logic [7:0]          seed,
  input  logic                err_inject,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    frame_cnt,
  output logic [DATA_W-1:0]   tx_axis_tdata,
  output logic [DATA_W/8-1:0] tx_axis_tkeep,
  output logic                tx_axis_tvalid,
  input  logic                tx_axis_tready,
  output logic                tx_axis_tlast,
  output logic                tx_axis_tuser
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int LANE_W = $clog2(KEEP_W);
  localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} stateT;
  stateT state, stateNext;

  logic [LEN_W-1:0]  lenLat, numLat, beatIdx, cntInc, selIdx, selLen;
  logic [7:0]        seedLat, selSeed;
  logic              errLat, abortSeen, selErr;
  logic [GAP_W-1:0]  gapCnt;
  logic              fire, lastNow, abortEff, burstEnd, gapLast, startOk;
  logic              emit, hold, beatLast;
  logic [KEEP_W-1:0] beatKeep;
  logic [DATA_W-1:0] beatData;

  function automatic logic lastBeatOf(input logic [LEN_W-1:0] len, input logic [LEN_W-1:0] idx);
    logic [LEN_W:0] beats;
    beats = ({1'b0, len} + (LEN_W+1)'(KEEP_W - 1)) >> LANE_W;
    return {1'b0, idx} == (beats - 1'b1);
  endfunction

  // A full final beat (remainder 0) keeps every lane.
  function automatic logic [KEEP_W-1:0] keepOf(input logic [LEN_W-1:0] len, input logic last);
    logic [LANE_W-1:0] rem;
    rem = len[LANE_W-1:0];
    if (!last || rem == '0) return '1;
    return KEEP_W'((1 << rem) - 1);
  endfunction

  function automatic logic [DATA_W-1:0] dataOf(input logic [7:0] seedV, input logic [LEN_W-1:0] idx,
                                               input logic [KEEP_W-1:0] keep);
    logic [DATA_W-1:0] d;
    logic [7:0]        base;
    d    = '0;
    base = seedV + 8'(idx << LANE_W);
    for (int k = 0; k < KEEP_W; k++)
      if (keep[k]) d[8*k +: 8] = base + 8'(k);
    return d;
  endfunction

  assign fire     = tx_axis_tvalid & tx_axis_tready;
  assign lastNow  = fire & tx_axis_tlast;
  assign abortEff = abortSeen | abort;
  assign cntInc   = frame_cnt + 1'b1;
  assign burstEnd = (cntInc == numLat) | abortEff;
  assign gapLast  = (gapCnt == GAP_LAST);
  assign startOk  = start && (frame_len != '0) && (num_frames != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (startOk) stateNext = SEND;
      SEND: if (lastNow) begin
              if (burstEnd)            stateNext = IDLE;
              else if (IFG_CYCLES > 0) stateNext = GAP;
            end
      GAP:  if (gapLast) stateNext = abortEff ? IDLE : SEND;
      default: stateNext = IDLE;
    endcase
  end

  // Selects which beat (if any) is presented next; a stalled beat is held as-is.
  always_comb begin
    emit    = 1'b0;
    hold    = 1'b0;
    selIdx  = '0;
    selSeed = seedLat;
    selLen  = lenLat;
    selErr  = errLat;
    unique case (state)
      IDLE: if (startOk) begin
              emit    = 1'b1;
              selSeed = seed;
              selLen  = frame_len;
              selErr  = err_inject;
            end
      SEND: if (!fire)                   hold = 1'b1;
            else if (!tx_axis_tlast) begin
              emit   = 1'b1;
              selIdx = beatIdx + 1'b1;
            end
            else if (stateNext == SEND)  emit = 1'b1;
      GAP:  if (stateNext == SEND)       emit = 1'b1;
      default: ;
    endcase
    beatLast = lastBeatOf(selLen, selIdx);
    beatKeep = keepOf(selLen, beatLast);
    beatData = dataOf(selSeed, selIdx, beatKeep);
  end

  // Output register stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      frame_cnt      <= '0;
      lenLat         <= '0;
      numLat         <= '0;
      seedLat        <= '0;
      errLat         <= 1'b0;
      abortSeen      <= 1'b0;
      beatIdx        <= '0;
      gapCnt         <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tkeep  <= '0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tuser  <= 1'b0;
    end else begin
      busy   <= (stateNext != IDLE);
      done   <= (state != IDLE) && (stateNext == IDLE);
      gapCnt <= (state == GAP) ? gapCnt + 1'b1 : '0;
      if (state == IDLE && startOk) begin
        lenLat    <= frame_len;
        numLat    <= num_frames;
        seedLat   <= seed;
        errLat    <= err_inject;
        abortSeen <= 1'b0;
        frame_cnt <= '0;
      end else begin
        if (state != IDLE && abort) abortSeen <= 1'b1;
        if (lastNow)                frame_cnt <= cntInc;
      end
      if (emit) begin
        beatIdx        <= selIdx;
        tx_axis_tvalid <= 1'b1;
        tx_axis_tdata  <= beatData;
        tx_axis_tkeep  <= beatKeep;
        tx_axis_tlast  <= beatLast;
        tx_axis_tuser  <= selErr & beatLast;
      end else if (!hold) begin
        tx_axis_tvalid <= 1'b0;
        tx_axis_tdata  <= '0;
        tx_axis_tkeep  <= '0;
        tx_axis_tlast  <= 1'b0;
        tx_axis_tuser  <= 1'b0;
      end
    end
  end

endmodule
